// File: rtl/axi_arb_pkg.sv
// Shared types for the per-slave AXI arbiter.
//   arb_state_e : burst-tracking FSM states
//   arb_dir_e   : direction of the granted burst
//   GRANT_NONE  : grant index meaning "no master" (sliced to the grant width)
package axi_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WDATA = 3'd4,
        S_WRESP = 3'd5
    } arb_state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } arb_dir_e;

    localparam logic [7:0] GRANT_NONE = '0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    in  N         request vector
//   ptr    in  IDX_BITS  highest-priority index (0..N-1)
//   valid  out 1         any request present
//   winner out IDX_BITS  first requester at/after ptr, wrapping modulo N
module rr_pick #(
    parameter int N        = 3,
    parameter int IDX_BITS = 2
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic                valid,
    output logic [IDX_BITS-1:0] winner
);

    logic                hi_v;
    logic [IDX_BITS-1:0] hi_w;
    logic [IDX_BITS-1:0] lo_w;

    // Scan high to low so the last hit is the lowest index: hi_* is the
    // lowest requester at/after ptr, lo_* the lowest overall (the wrap case).
    always_comb begin
        hi_v = 1'b0;
        hi_w = '0;
        lo_w = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_w = IDX_BITS'(i);
                if (IDX_BITS'(i) >= ptr) begin
                    hi_v = 1'b1;
                    hi_w = IDX_BITS'(i);
                end
            end
        end
        valid  = |req;
        winner = hi_v ? hi_w : lo_w;
    end

endmodule

// File: rtl/axi_slave_rr_arbiter.sv
// Per-slave AXI arbiter: one instance per crossbar slave port.
// Grants one master (read or write) by round-robin and holds the grant for a
// whole burst (address -> data -> RLAST / B response). A watchdog releases the
// slave if no handshake occurs for TIMEOUT_CYC cycles.
// Ports:
//   clk, rst                    clock, async active-low reset
//   ar_req / aw_req   [NUM_M]   ARVALID / AWVALID of masters decoded to this slave
//   *_sel                       granted master's signals (crossbar mux outputs)
//   *_s                         slave-side handshake signals
//   grant_rd/grant_wr [MIDX]    0 = none, m+1 = master m
//   busy                        FSM not idle
//   timeout                     one-cycle pulse on watchdog release
module axi_slave_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M       = 3,
    parameter int MIDX_BITS   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_M-1:0]     ar_req,
    input  logic [NUM_M-1:0]     aw_req,
    input  logic                 arvalid_sel,
    input  logic                 arready_s,
    input  logic                 rvalid_s,
    input  logic                 rlast_s,
    input  logic                 rready_sel,
    input  logic                 awvalid_sel,
    input  logic                 awready_s,
    input  logic                 wvalid_sel,
    input  logic                 wlast_sel,
    input  logic                 wready_s,
    input  logic                 bvalid_s,
    input  logic                 bready_sel,
    output logic [MIDX_BITS-1:0] grant_rd,
    output logic [MIDX_BITS-1:0] grant_wr,
    output logic                 busy,
    output logic                 timeout
);

    localparam int                   CNT_W  = $clog2(TIMEOUT_CYC);
    localparam logic [MIDX_BITS-1:0] G_NONE = GRANT_NONE[MIDX_BITS-1:0];
    localparam logic [MIDX_BITS-1:0] LAST_M = MIDX_BITS'(NUM_M - 1);
    localparam logic [CNT_W-1:0]     WD_MAX = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e           state_q, state_d;
    arb_dir_e             last_dir_q, last_dir_d;
    logic [MIDX_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MIDX_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MIDX_BITS-1:0] grant_rd_q, grant_rd_d;
    logic [MIDX_BITS-1:0] grant_wr_q, grant_wr_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     wdog_q, wdog_d;

    logic                 rd_vld, wr_vld;
    logic [MIDX_BITS-1:0] rd_win, wr_win;
    logic                 progress;
    logic                 pick_rd;

    rr_pick #(.N(NUM_M), .IDX_BITS(MIDX_BITS)) u_pick_rd (
        .req(ar_req), .ptr(rd_ptr_q), .valid(rd_vld), .winner(rd_win)
    );

    rr_pick #(.N(NUM_M), .IDX_BITS(MIDX_BITS)) u_pick_wr (
        .req(aw_req), .ptr(wr_ptr_q), .valid(wr_vld), .winner(wr_win)
    );

    // Both directions requesting: serve the one not served last time.
    assign pick_rd = rd_vld && (!wr_vld || last_dir_q == WR);

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        grant_rd_d = grant_rd_q;
        grant_wr_d = grant_wr_q;
        timeout_d  = 1'b0;
        wdog_d     = '0;
        progress   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_rd) begin
                    state_d    = S_RADDR;
                    grant_rd_d = rd_win + MIDX_BITS'(1);
                    rd_ptr_d   = (rd_win == LAST_M) ? '0 : rd_win + MIDX_BITS'(1);
                    last_dir_d = RD;
                end else if (wr_vld) begin
                    state_d    = S_WADDR;
                    grant_wr_d = wr_win + MIDX_BITS'(1);
                    wr_ptr_d   = (wr_win == LAST_M) ? '0 : wr_win + MIDX_BITS'(1);
                    last_dir_d = WR;
                end
            end
            S_RADDR: begin
                if (arvalid_sel && arready_s) begin
                    progress = 1'b1;
                    state_d  = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid_s && rready_sel) begin
                    progress = 1'b1;
                    if (rlast_s) begin
                        state_d    = S_IDLE;
                        grant_rd_d = G_NONE;
                    end
                end
            end
            S_WADDR: begin
                if (awvalid_sel && awready_s) begin
                    progress = 1'b1;
                    state_d  = S_WDATA;
                end
            end
            S_WDATA: begin
                if (wvalid_sel && wready_s) begin
                    progress = 1'b1;
                    if (wlast_sel) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid_s && bready_sel) begin
                    progress   = 1'b1;
                    state_d    = S_IDLE;
                    grant_wr_d = G_NONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                grant_rd_d = G_NONE;
                grant_wr_d = G_NONE;
            end
        endcase

        // Watchdog: stays zero in IDLE, so every entry into a busy state starts
        // from zero. Any handshake restarts the count.
        if (state_q != S_IDLE && !progress) begin
            if (wdog_q == WD_MAX) begin
                state_d    = S_IDLE;
                grant_rd_d = G_NONE;
                grant_wr_d = G_NONE;
                timeout_d  = 1'b1;
            end else begin
                wdog_d = wdog_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            last_dir_q <= WR;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            grant_rd_q <= G_NONE;
            grant_wr_q <= G_NONE;
            timeout_q  <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            grant_rd_q <= grant_rd_d;
            grant_wr_q <= grant_wr_d;
            timeout_q  <= timeout_d;
            wdog_q     <= wdog_d;
        end
    end

    assign grant_rd = grant_rd_q;
    assign grant_wr = grant_wr_q;
    assign busy     = (state_q != S_IDLE);
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_axi_slave_rr_arbiter.sv
// Self-checking bench for axi_slave_rr_arbiter. A transaction-level model
// (per-direction pointers and last direction, plain modulo arithmetic) predicts
// the winner of each arbitration; the bench plays crossbar and slave.
module tb_axi_slave_rr_arbiter;

    localparam int NM = 3;
    localparam int MB = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NM-1:0] ar_req, aw_req;
    logic          arvalid_sel, arready_s, rvalid_s, rlast_s, rready_sel;
    logic          awvalid_sel, awready_s, wvalid_sel, wlast_sel, wready_s;
    logic          bvalid_s, bready_sel;
    logic [MB-1:0] grant_rd, grant_wr;
    logic          busy, timeout;

    int checks = 0;
    int errors = 0;
    int m_ptr[2];   // model round-robin pointers: [0] read, [1] write
    int m_last;     // model last direction: 0 read, 1 write
    int stall_run;
    int b_hold;
    int dir, mst, ar, aw;
    bit hs;

    axi_slave_rr_arbiter #(.NUM_M(NM), .MIDX_BITS(MB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ar_req(ar_req), .aw_req(aw_req),
        .arvalid_sel(arvalid_sel), .arready_s(arready_s), .rvalid_s(rvalid_s),
        .rlast_s(rlast_s), .rready_sel(rready_sel), .awvalid_sel(awvalid_sel),
        .awready_s(awready_s), .wvalid_sel(wvalid_sel), .wlast_sel(wlast_sel),
        .wready_s(wready_s), .bvalid_s(bvalid_s), .bready_sel(bready_sel),
        .grant_rd(grant_rd), .grant_wr(grant_wr), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout observed no finish required finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int gr, input int gw, input bit bz, input bit to);
        chk({tag, ".grant_rd"}, 32'(grant_rd), 32'(gr));
        chk({tag, ".grant_wr"}, 32'(grant_wr), 32'(gw));
        chk({tag, ".busy"},     32'(busy),     32'(bz));
        chk({tag, ".timeout"},  32'(timeout),  32'(to));
    endtask

    task automatic clear_bus();
        arvalid_sel = 0; arready_s = 0; rvalid_s = 0; rlast_s = 0; rready_sel = 0;
        awvalid_sel = 0; awready_s = 0; wvalid_sel = 0; wlast_sel = 0; wready_s = 0;
        bvalid_s = 0; bready_sel = 0;
    endtask

    task automatic model_reset();
        m_ptr[0] = 0;
        m_ptr[1] = 0;
        m_last   = 1;
    endtask

    // Arbitration rule: lone side wins; both sides -> opposite of last served;
    // within a side, first requester scanning upward from the pointer, wrapping.
    task automatic predict(input int rq_r, input int rq_w, output int d, output int m);
        int v;
        d = -1;
        m = -1;
        if (rq_r == 0 && rq_w == 0) return;
        if (rq_r != 0 && rq_w != 0) d = (m_last == 1) ? 0 : 1;
        else                        d = (rq_r != 0) ? 0 : 1;
        v = (d == 0) ? rq_r : rq_w;
        for (int k = 0; k < NM; k++) begin
            if (m < 0 && ((v >> ((m_ptr[d] + k) % NM)) & 1) == 1) m = (m_ptr[d] + k) % NM;
        end
        m_ptr[d] = (m + 1) % NM;
        m_last   = d;
    endtask

    // Present requests in IDLE; the grant must appear right after the next edge.
    task automatic issue(input int rq_r, input int rq_w, input bit hold, output int d, output int m);
        ar_req = NM'(rq_r);
        aw_req = NM'(rq_w);
        predict(rq_r, rq_w, d, m);
        tick();
        if (d < 0) chk_state("idle_noreq", 0, 0, 0, 0);
        else       chk_state("grant", (d == 0) ? m + 1 : 0, (d == 1) ? m + 1 : 0, 1, 0);
        if (!hold) begin
            ar_req = '0;
            aw_req = '0;
        end
    endtask

    // One cycle of a phase: 0 AR, 1 R, 2 AW, 3 W, 4 B. Random stalls are capped
    // at three in a row so the watchdog never fires during normal bursts.
    task automatic step(input int ph, input bit last, input bit rnd, output bit h);
        bit v, r;
        v = 1;
        r = 1;
        if (rnd && stall_run < 3) begin
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
        end
        if (ph == 4 && b_hold > 0) begin
            v = 0;
            b_hold--;
        end
        clear_bus();
        case (ph)
            0: begin arvalid_sel = v; arready_s = r; end
            1: begin rvalid_s = v; rready_sel = r; rlast_s = last; end
            2: begin awvalid_sel = v; awready_s = r; end
            3: begin wvalid_sel = v; wready_s = r; wlast_sel = last; end
            default: begin bvalid_s = v; bready_sel = r; end
        endcase
        h = v && r;
        stall_run = h ? 0 : stall_run + 1;
        tick();
    endtask

    // Run a whole burst from the address phase; grant must hold until the final
    // handshake and drop right after it.
    task automatic burst(input int d, input int m, input int len, input bit rnd);
        int    phs[$];
        int    n, cnt, guard;
        bit    h, done;
        string tg;
        if (d == 0) phs = '{0, 1};
        else        phs = '{2, 3, 4};
        stall_run = 0;
        foreach (phs[p]) begin
            n = (phs[p] == 1 || phs[p] == 3) ? len : 1;
            cnt = 0;
            guard = 0;
            while (cnt < n && guard < 64) begin
                step(phs[p], cnt == n - 1, rnd, h);
                if (h) cnt++;
                guard++;
                done = (p == phs.size() - 1) && (cnt == n);
                if (done) tg = "release";
                else      tg = "hold";
                chk_state(tg, (!done && d == 0) ? m + 1 : 0, (!done && d == 1) ? m + 1 : 0, !done, 0);
            end
            if (cnt < n) begin
                checks++;
                errors++;
                $display("FAIL burst_guard phase %0d observed %0d handshakes required %0d", phs[p], cnt, n);
                clear_bus();
                return;
            end
        end
        clear_bus();
    endtask

    initial begin
        ar_req = '0;
        aw_req = '0;
        clear_bus();
        model_reset();
        b_hold = 0;
        stall_run = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0);
        #3 rst = 1'b1;

        // Fairness: all three readers, six one-beat reads -> 1,2,3,1,2,3.
        for (int i = 0; i < 6; i++) begin
            issue(7, 0, 1, dir, mst);
            chk("rr_seq", 32'(grant_rd), 32'((i % 3) + 1));
            burst(dir, mst, 1, 0);
        end

        // Single 4-beat read from master 1 with no stalls.
        issue(2, 0, 0, dir, mst);
        chk("single_rd", 32'(grant_rd), 32'(2));
        burst(dir, mst, 4, 0);

        // Read/write alternation with both sides requesting.
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 1, dir, mst);
            burst(dir, mst, 1, 1);
        end

        // Write path: master 2, 2 beats with stalls, B delayed 5 cycles.
        b_hold = 5;
        issue(0, 4, 0, dir, mst);
        chk("wr_path", 32'(grant_wr), 32'(3));
        burst(dir, mst, 2, 1);
        b_hold = 0;

        // Watchdog: AR handshake then R never comes.
        issue(7, 0, 0, dir, mst);
        step(0, 0, 0, hs);
        chk_state("wd_addr", mst + 1, 0, 1, 0);
        clear_bus();
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k < TO)       chk_state("wd_wait", mst + 1, 0, 1, 0);
            else if (k == TO) chk_state("wd_fire", 0, 0, 0, 1);
            else              chk_state("wd_after", 0, 0, 0, 0);
        end
        issue(7, 0, 0, dir, mst);
        burst(dir, mst, 2, 1);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            ar = int'($urandom_range(0, 7));
            aw = int'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                ar = 0;
                aw = 0;
            end
            if ($urandom_range(0, 3) == 0) b_hold = int'($urandom_range(1, 6));
            issue(ar, aw, $urandom_range(0, 1) == 1, dir, mst);
            if (dir >= 0) burst(dir, mst, int'($urandom_range(1, 6)), 1);
            b_hold = 0;
        end

        // Async reset in RDATA: outputs drop before the next clock edge.
        issue(2, 0, 0, dir, mst);
        step(0, 0, 0, hs);
        step(1, 0, 0, hs);
        chk_state("pre_rst", mst + 1, 0, 1, 0);
        #3 rst = 1'b0;
        #1 chk_state("async_rst", 0, 0, 0, 0);
        #2 rst = 1'b1;
        clear_bus();
        model_reset();
        issue(7, 0, 0, dir, mst);
        chk("rst_ptr", 32'(grant_rd), 32'(1));
        burst(dir, mst, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
